// File: rtl/flash_audio_addr_ctrl_if.sv
// Avalon-MM read bus between the audio address controller and the flash.
interface flash_audio_addr_ctrl_if #(
    parameter int ADDR_W = 23
);
    logic              flash_read;
    logic [ADDR_W-1:0] flash_address;
    logic              flash_waitrequest;
    logic [31:0]       flash_readdata;
    logic              flash_readdatavalid;

    modport master (
        output flash_read,
        output flash_address,
        input  flash_waitrequest,
        input  flash_readdata,
        input  flash_readdatavalid
    );

    modport slave (
        input  flash_read,
        input  flash_address,
        output flash_waitrequest,
        output flash_readdata,
        output flash_readdatavalid
    );
endinterface

// File: rtl/flash_audio_addr_ctrl.sv
// Audio playback address controller: latches play/pause and direction from
// the keyboard decoder, fetches one 32-bit flash word per two sample ticks
// and emits its 16-bit halves in direction-dependent order.
module flash_audio_addr_ctrl #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_d,
    input  logic                     cmd_e,
    input  logic                     cmd_b,
    input  logic                     cmd_f,
    input  logic                     cmd_r,
    input  logic                     sample_tick,
    flash_audio_addr_ctrl_if.master  flash,
    output logic [15:0]              audio_sample,
    output logic                     sample_valid,
    output logic                     playing,
    output logic                     forward
);

    typedef enum logic [2:0] {
        IDLE, READ, WAIT_DATA, EMIT1, WAIT_TICK2, EMIT2, STEP
    } state_t;

    state_t            state;
    logic [31:0]       word;
    logic              word_fwd;   // direction frozen for the word in flight
    logic              discard;    // restart hit an outstanding read
    logic              pend;       // restart address waiting for the read to be accepted
    logic [ADDR_W-1:0] pend_addr;
    logic              fwd_nxt;
    logic [ADDR_W-1:0] rst_tgt;

    // Next address with wrap at either end of the clip.
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                    input logic fwd);
        if (fwd)
            return (a == END_ADDR) ? START_ADDR : a + ADDR_W'(1);
        else
            return (a == START_ADDR) ? END_ADDR : a - ADDR_W'(1);
    endfunction

    // Restart uses the direction as updated by this cycle's F/B levels.
    assign fwd_nxt = cmd_f ? 1'b1 : (cmd_b ? 1'b0 : forward);
    assign rst_tgt = fwd_nxt ? START_ADDR : END_ADDR;

    // Capture the returned flash word; a discarded word is simply never emitted.
    always_ff @(posedge clk) begin
        if (state == WAIT_DATA && flash.flash_readdatavalid)
            word <= flash.flash_readdata;
    end

    // Hold the restart target while a stalled read keeps the address frozen.
    always_ff @(posedge clk) begin
        if (state == READ && cmd_r)
            pend_addr <= rst_tgt;
    end

    // Command latches and the fetch/emit/step sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            playing             <= 1'b0;
            forward             <= 1'b1;
            flash.flash_address <= START_ADDR;
            flash.flash_read    <= 1'b0;
            audio_sample        <= 16'h0000;
            sample_valid        <= 1'b0;
            word_fwd            <= 1'b1;
            discard             <= 1'b0;
            pend                <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            playing      <= cmd_d ? 1'b0 : (cmd_e ? 1'b1 : playing);
            forward      <= fwd_nxt;
            if (cmd_r && state != READ && state != WAIT_DATA) begin
                flash.flash_address <= rst_tgt;
                state               <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (sample_tick && playing) begin
                            flash.flash_read <= 1'b1;
                            state            <= READ;
                        end
                    end
                    READ: begin
                        if (cmd_r)
                            discard <= 1'b1;
                        if (!flash.flash_waitrequest) begin
                            flash.flash_read <= 1'b0;
                            pend             <= 1'b0;
                            state            <= WAIT_DATA;
                            if (cmd_r)
                                flash.flash_address <= rst_tgt;
                            else if (pend)
                                flash.flash_address <= pend_addr;
                        end else if (cmd_r) begin
                            pend <= 1'b1;
                        end
                    end
                    WAIT_DATA: begin
                        if (cmd_r)
                            flash.flash_address <= rst_tgt;
                        if (flash.flash_readdatavalid) begin
                            discard <= 1'b0;
                            state   <= (discard || cmd_r) ? IDLE : EMIT1;
                        end else if (cmd_r) begin
                            discard <= 1'b1;
                        end
                    end
                    EMIT1: begin
                        audio_sample <= forward ? word[15:0] : word[31:16];
                        word_fwd     <= forward;
                        sample_valid <= 1'b1;
                        state        <= WAIT_TICK2;
                    end
                    WAIT_TICK2: begin
                        if (sample_tick && playing)
                            state <= EMIT2;
                    end
                    EMIT2: begin
                        audio_sample <= word_fwd ? word[31:16] : word[15:0];
                        sample_valid <= 1'b1;
                        state        <= STEP;
                    end
                    STEP: begin
                        flash.flash_address <= step_addr(flash.flash_address, word_fwd);
                        state               <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_audio_addr_ctrl.sv
// Bench for flash_audio_addr_ctrl: randomized flash slave timing and data,
// checked against a word-level playback model.
module tb_flash_audio_addr_ctrl;

    localparam logic [22:0] START_A = 23'h000000;
    localparam logic [22:0] END_A   = 23'h07FFFF;
    localparam longint      N_WORDS = longint'(END_A) - longint'(START_A) + 1;

    logic        clk, reset;
    logic        cmd_d, cmd_e, cmd_b, cmd_f, cmd_r, sample_tick;
    logic [15:0] audio_sample;
    logic        sample_valid, playing, forward;

    flash_audio_addr_ctrl_if #(.ADDR_W(23)) bus ();

    flash_audio_addr_ctrl #(.ADDR_W(23), .START_ADDR(START_A), .END_ADDR(END_A)) dut (
        .clk(clk), .reset(reset),
        .cmd_d(cmd_d), .cmd_e(cmd_e), .cmd_b(cmd_b), .cmd_f(cmd_f), .cmd_r(cmd_r),
        .sample_tick(sample_tick), .flash(bus),
        .audio_sample(audio_sample), .sample_valid(sample_valid),
        .playing(playing), .forward(forward)
    );

    int checks = 0;
    int failures = 0;

    // model state
    bit          m_play, m_fwd;
    logic [22:0] m_addr;

    // slave configuration and observation
    int          cfg_stall, cfg_rdv;
    bit          fixed_mode;
    logic [31:0] fixed_word, salt;
    bit          in_req, rdv_pend;
    int          stall_left, rdv_left;
    logic [22:0] req_addr;
    logic [31:0] resp;
    int          n_acc, addr_viol;
    logic [15:0] got_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] data_of(input logic [22:0] a);
        return {a[15:0] ^ salt[31:16], {a[22:16], a[8:0]} ^ salt[15:0]};
    endfunction

    // Avalon slave and sample monitor, all activity on the falling edge.
    initial begin
        bus.flash_waitrequest = 1'b0; bus.flash_readdatavalid = 1'b0; bus.flash_readdata = '0;
        in_req = 0; rdv_pend = 0; n_acc = 0; addr_viol = 0; stall_left = 0; rdv_left = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_req = 0; rdv_pend = 0;
                bus.flash_waitrequest = 1'b0; bus.flash_readdatavalid = 1'b0;
            end else begin
                if (sample_valid) got_q.push_back(audio_sample);
                bus.flash_readdatavalid = 1'b0;
                if (rdv_pend) begin
                    if (rdv_left == 0) begin
                        bus.flash_readdatavalid = 1'b1; bus.flash_readdata = resp; rdv_pend = 0;
                    end else rdv_left--;
                end
                if (in_req && !bus.flash_read) begin addr_viol++; in_req = 0; end
                if (bus.flash_read && !in_req) begin
                    in_req = 1; stall_left = cfg_stall; req_addr = bus.flash_address;
                end
                if (in_req) begin
                    if (bus.flash_address !== req_addr) addr_viol++;
                    if (stall_left > 0) begin
                        bus.flash_waitrequest = 1'b1; stall_left--;
                    end else begin
                        bus.flash_waitrequest = 1'b0; in_req = 0; n_acc++;
                        rdv_pend = 1; rdv_left = cfg_rdv;
                        resp = fixed_mode ? fixed_word : data_of(req_addr);
                    end
                end else bus.flash_waitrequest = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle of command levels / tick, with the model following the command rules.
    task automatic drive(input bit d, input bit e, input bit b, input bit f, input bit r, input bit tk);
        cmd_d = d; cmd_e = e; cmd_b = b; cmd_f = f; cmd_r = r; sample_tick = tk;
        cyc();
        cmd_d = 0; cmd_e = 0; cmd_b = 0; cmd_f = 0; cmd_r = 0; sample_tick = 0;
        if (d) m_play = 0; else if (e) m_play = 1;
        if (f) m_fwd = 1; else if (b) m_fwd = 0;
        if (r) m_addr = m_fwd ? START_A : END_A;
    endtask

    task automatic model_step();
        longint off;
        off = (longint'(m_addr) - longint'(START_A) + (m_fwd ? 64'sd1 : N_WORDS - 1)) % N_WORDS;
        m_addr = 23'(longint'(START_A) + off);
    endtask

    // Play one whole word (two ticks) and check both samples and the address step.
    task automatic play_word(input string tag);
        logic [31:0] d;
        logic [15:0] e1, e2;
        int n0, acc0, rd_hi;
        bit ok;
        checks++;
        if (bus.flash_address !== m_addr) begin
            failures++;
            $display("FAIL %s_addr_before: got %h expected %h", tag, bus.flash_address, m_addr);
        end
        d  = fixed_mode ? fixed_word : data_of(m_addr);
        e1 = m_fwd ? d[15:0] : d[31:16];
        e2 = m_fwd ? d[31:16] : d[15:0];
        n0 = got_q.size(); acc0 = n_acc; rd_hi = 0; ok = 0;
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 80 && !ok; i++) begin
            if (got_q.size() > n0) ok = 1;
            else begin
                if (bus.flash_read) rd_hi++;
                cyc();
            end
        end
        checks++;
        if (!ok) begin
            failures++; $display("FAIL %s_first: got no sample expected %h", tag, e1);
        end else if (got_q[n0] !== e1) begin
            failures++; $display("FAIL %s_first: got %h expected %h", tag, got_q[n0], e1);
        end
        checks++;
        if (rd_hi !== cfg_stall + 1) begin
            failures++; $display("FAIL %s_read_cycles: got %0d expected %0d", tag, rd_hi, cfg_stall + 1);
        end
        repeat ($urandom_range(0, 3)) cyc();
        drive(0, 0, 0, 0, 0, 1);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (got_q.size() > n0 + 1) ok = 1; else cyc();
        end
        checks++;
        if (!ok) begin
            failures++; $display("FAIL %s_second: got no sample expected %h", tag, e2);
        end else if (got_q[n0 + 1] !== e2) begin
            failures++; $display("FAIL %s_second: got %h expected %h", tag, got_q[n0 + 1], e2);
        end
        repeat (3) cyc();
        checks++;
        if (n_acc !== acc0 + 1 || got_q.size() !== n0 + 2) begin
            failures++;
            $display("FAIL %s_counts: got reads=%0d samples=%0d expected reads=%0d samples=%0d",
                     tag, n_acc - acc0, got_q.size() - n0, 1, 2);
        end
        model_step();
        checks++;
        if (bus.flash_address !== m_addr) begin
            failures++; $display("FAIL %s_addr_after: got %h expected %h", tag, bus.flash_address, m_addr);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) cyc();
        m_play = 0; m_fwd = 1; m_addr = START_A;
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL rst_playing: got %b expected 0", playing); end
        checks++; if (forward !== 1'b1) begin failures++; $display("FAIL rst_forward: got %b expected 1", forward); end
        checks++; if (bus.flash_address !== START_A) begin failures++; $display("FAIL rst_addr: got %h expected %h", bus.flash_address, START_A); end
        checks++; if (bus.flash_read !== 1'b0) begin failures++; $display("FAIL rst_read: got %b expected 0", bus.flash_read); end
        checks++; if (audio_sample !== 16'h0) begin failures++; $display("FAIL rst_sample: got %h expected 0000", audio_sample); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", sample_valid); end
        reset = 0;
        cyc();
    endtask

    task automatic test_basic();
        fixed_mode = 1; fixed_word = 32'hBBBB_AAAA; cfg_stall = 0; cfg_rdv = 0;
        drive(0, 1, 0, 0, 0, 0);
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL basic_play: got %b expected 1", playing); end
        play_word("basic");
    endtask

    task automatic test_random_words();
        fixed_mode = 0;
        for (int w = 0; w < 10; w++) begin
            cfg_stall = $urandom_range(0, 3);
            cfg_rdv   = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) drive(0, 0, 0, 1, 0, 0);
                else drive(0, 0, 1, 0, 0, 0);
            end
            play_word("rand");
        end
    endtask

    task automatic test_wrap();
        fixed_mode = 1; fixed_word = 32'hBBBB_AAAA; cfg_stall = 0; cfg_rdv = 1;
        drive(0, 0, 1, 0, 1, 0);   // backward restart lands on the last word
        drive(0, 0, 0, 1, 0, 0);
        play_word("wrap_fwd");
        drive(0, 0, 1, 0, 0, 0);
        play_word("wrap_bwd");
        checks++; if (got_q[got_q.size() - 2] !== 16'hBBBB) begin failures++; $display("FAIL wrap_bwd_order: got %h expected BBBB", got_q[got_q.size() - 2]); end
    endtask

    task automatic test_stall();
        fixed_mode = 0; cfg_stall = 5; cfg_rdv = 1;
        play_word("stall");
        checks++; if (addr_viol !== 0) begin failures++; $display("FAIL stall_addr_stable: got %0d violations expected 0", addr_viol); end
        cfg_stall = 0;
    endtask

    task automatic test_pause();
        int acc0, n0;
        logic [22:0] a0;
        drive(1, 0, 0, 0, 0, 0);
        acc0 = n_acc; n0 = got_q.size(); a0 = bus.flash_address;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            repeat (3) cyc();
        end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL pause_playing: got %b expected 0", playing); end
        checks++; if (n_acc !== acc0) begin failures++; $display("FAIL pause_reads: got %0d expected 0", n_acc - acc0); end
        checks++; if (got_q.size() !== n0) begin failures++; $display("FAIL pause_samples: got %0d expected 0", got_q.size() - n0); end
        checks++; if (bus.flash_address !== a0) begin failures++; $display("FAIL pause_addr: got %h expected %h", bus.flash_address, a0); end
        drive(0, 1, 0, 0, 0, 0);
        play_word("resume");
    endtask

    task automatic test_restart();
        int n0;
        fixed_mode = 0;
        drive(0, 0, 0, 1, 1, 0);
        for (int w = 0; w < 256; w++) begin
            cfg_stall = $urandom_range(0, 1);
            cfg_rdv   = $urandom_range(0, 1);
            play_word("adv");
        end
        checks++; if (bus.flash_address !== 23'h000100) begin failures++; $display("FAIL adv_addr: got %h expected 000100", bus.flash_address); end
        drive(0, 0, 0, 0, 1, 0);
        checks++; if (bus.flash_address !== m_addr) begin failures++; $display("FAIL restart_fwd: got %h expected %h", bus.flash_address, m_addr); end
        drive(0, 0, 1, 0, 1, 0);
        checks++; if (bus.flash_address !== m_addr) begin failures++; $display("FAIL restart_bwd: got %h expected %h", bus.flash_address, m_addr); end
        checks++; if (forward !== 1'b0) begin failures++; $display("FAIL restart_bwd_dir: got %b expected 0", forward); end
        // restart while the read data is still outstanding
        cfg_stall = 0; cfg_rdv = 6;
        play_word("pre_discard");
        n0 = got_q.size();
        drive(0, 0, 0, 0, 0, 1);
        cyc();
        drive(0, 0, 0, 0, 1, 0);
        repeat (20) cyc();
        checks++; if (got_q.size() !== n0) begin failures++; $display("FAIL discard_samples: got %0d expected 0", got_q.size() - n0); end
        checks++; if (bus.flash_address !== m_addr) begin failures++; $display("FAIL discard_addr: got %h expected %h", bus.flash_address, m_addr); end
        cfg_rdv = 0;
        play_word("post_discard");
    endtask

    task automatic test_conflict();
        drive(0, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        checks++; if (playing !== m_play) begin failures++; $display("FAIL de_conflict: got %b expected %b", playing, m_play); end
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 0, 0);
        checks++; if (forward !== m_fwd) begin failures++; $display("FAIL fb_conflict: got %b expected %b", forward, m_fwd); end
    endtask

    task automatic test_reset_mid();
        // reset while a stalled read is on the bus
        cfg_stall = 10; cfg_rdv = 0;
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        #2 reset = 1;
        #1;
        checks++; if (bus.flash_read !== 1'b0) begin failures++; $display("FAIL rmid_read: got %b expected 0", bus.flash_read); end
        cyc();
        reset = 0; m_play = 0; m_fwd = 1; m_addr = START_A;
        cyc();
        // reset while waiting for read data, after moving away from reset values
        cfg_stall = 0; cfg_rdv = 8;
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        cyc();
        #2 reset = 1;
        #1;
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL rwd_playing: got %b expected 0", playing); end
        checks++; if (forward !== 1'b1) begin failures++; $display("FAIL rwd_forward: got %b expected 1", forward); end
        checks++; if (bus.flash_address !== START_A) begin failures++; $display("FAIL rwd_addr: got %h expected %h", bus.flash_address, START_A); end
        checks++; if (audio_sample !== 16'h0 || sample_valid !== 1'b0) begin failures++; $display("FAIL rwd_sample: got %h/%b expected 0000/0", audio_sample, sample_valid); end
        cyc();
        reset = 0;
        cyc();
    endtask

    initial begin
        reset = 1; cmd_d = 0; cmd_e = 0; cmd_b = 0; cmd_f = 0; cmd_r = 0; sample_tick = 0;
        cfg_stall = 0; cfg_rdv = 0; fixed_mode = 0; fixed_word = '0;
        salt = $urandom;
        m_play = 0; m_fwd = 1; m_addr = START_A;
        test_reset();
        test_basic();
        test_random_words();
        test_wrap();
        test_stall();
        test_pause();
        test_restart();
        test_conflict();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
